multi_phase_oscillator: RTL
===========================

Name: multi_phase_oscillator

Overview:
- Parametrised successor to the single-output oscillator.
- Generates NUM_CH square waves that share one programmable period and one programmable high time; each channel has its own programmable phase offset.
- New configuration is taken through a valid/ready handshake and applied glitch-free at the period boundary.
- Sits in the clock/timing utility layer, driving PWM and strobe consumers.

Parameters:
- CNT_W, 16, width of period/high/phase fields and of all counters.
- NUM_CH, 4, number of output channels (1..16).
- DEF_PERIOD, 4, period after reset (cycles, ≥2).
- DEF_HIGH, 2, high time after reset (cycles).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config slot free.
- cfg_period  in  CNT_W  period in cycles.
- cfg_high  in  CNT_W  high cycles per period.
- cfg_phase  in  NUM_CH*CNT_W  per-channel phase offset; channel i occupies bits [i*CNT_W +: CNT_W].
- cfg_err  out  1  one-cycle pulse when an offered config is rejected.
- osc_out  out  NUM_CH  oscillator outputs (registered).
- period_start  out  1  one-cycle pulse when the master counter wraps to 0.

Behaviour:
- Reset (async assert, sync-safe release):
  - Active config: P=DEF_PERIOD, H=DEF_HIGH, all phases 0.
  - Master counter and all channel counters = 0.
  - osc_out=0, period_start=0, cfg_err=0, cfg_ready=1, FSM=IDLE.
- Counters:
  - The master counter m and each channel counter c_i advance by 1 per cycle while en=1.
  - Each counter wraps from P-1 to 0.
  - All arithmetic is unsigned CNT_W; no intermediate overflow, since values stay < P ≤ 2^CNT_W-1.
- Output, registered, 1-cycle latency:
  - osc_out[i] <= en & (c_i < H).
  - H=0 gives a constant 0; H≥P gives a constant 1.
- period_start <= en & (m == P-1).
- en=0:
  - All counters hold.
  - osc_out forced 0 next cycle.
  - period_start=0.
  - Resuming continues from the held counts.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = (FSM==IDLE).
- Validation at transfer:
  - Reject if cfg_period<2 or any phase_i ≥ cfg_period.
  - On reject: cfg_err pulses 1 the next cycle, nothing is stored, FSM stays IDLE.
  - Otherwise the config is latched into shadow registers and FSM moves to PENDING.
- FSM:
  - IDLE → PENDING on accepted transfer.
  - PENDING → IDLE on the apply event.
- Apply event, while in PENDING:
  - Occurs in the cycle where (en=1 and m==P-1), or in any cycle with en=0.
  - Action: P, H and phases take the shadow values; m <= 0; c_i <= phase_i.
  - When applied at a wrap, period_start still pulses for the old period.
  - New waveform is visible on osc_out from the second cycle after apply.
- Simultaneous events:
  - A transfer cannot coincide with PENDING, because cfg_ready=0.
  - A transfer arriving in the same cycle as a wrap while IDLE is not applied until the following wrap.
- rst mid-period or with a pending config: everything returns to reset values and the pending config is discarded.

Optional Feature:
- Macro: OSC_POLARITY_EN.
- Defined:
  - Adds input cfg_pol [NUM_CH], captured with the config and applied at the same apply event.
  - osc_out[i] <= en & ((c_i < H) ^ pol_i).
  - Reset pol=0.
  - Disabled outputs are still 0.
- Undefined: port absent; behaviour as above (pol fixed at 0).

Decomposition:
- Package osc_pkg:
  - FSM state enum (OSC_IDLE, OSC_PENDING).
  - Function for phase-slice extraction.
  - Validation function returning the error flag.
- One natural sub-module: osc_channel.
  - Contents: one channel counter, wrap compare, H compare, output register.
  - Instantiated NUM_CH times by generate.
  - Takes P, H, load, load_val, en.

Test Plan:
- Reset then en=1 with defaults (P=4, H=2): osc_out[0] = 0,1,1,0,0,1,1,0… starting 1 cycle after en; period_start every 4th cycle.
- Config P=10, H=3, phases {0,2,5,9} accepted mid-period: old waveform continues to the wrap, then ch0 high on cycles 0-2, ch1 on 8-0, ch2 on 5-7 (cycle indices relative to apply); cfg_ready low until apply.
- Rejected configs: cfg_period=1, or phase_3=10 with P=10 → cfg_err pulses once, waveform unchanged, cfg_ready stays 1.
- Boundary H: H=0 → all outputs 0; H=P=6 → all outputs 1; period_start still pulses every 6 cycles.
- en drop for 7 cycles at m=3 with P=8: outputs 0 during the gap, counters resume from 3; a config offered while en=0 applies immediately.
- rst asserted asynchronously while PENDING: outputs 0 in the same cycle, defaults restored, pending config lost (and, with OSC_POLARITY_EN, pol=1 on ch0 inverts only ch0 after apply).

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types and helpers for multi_phase_oscillator (optional feature macro: OSC_POLARITY_EN).
package osc_pkg;

    localparam int OSC_MAX_W  = 32;
    localparam int OSC_MAX_CH = 16;
    localparam int OSC_PHASE_BUS_W = OSC_MAX_CH * OSC_MAX_W;

    typedef enum logic {
        OSC_IDLE,
        OSC_PENDING
    } osc_state_e;

    // Helpers work on a bus widened to the largest supported geometry so that
    // any CNT_W/NUM_CH combination can share them.
    function automatic logic [OSC_MAX_W-1:0] phase_slice(
        input logic [OSC_PHASE_BUS_W-1:0] phases,
        input int                         idx,
        input int                         w
    );
        logic [OSC_MAX_W-1:0] mask;
        mask = (w >= OSC_MAX_W) ? '1 : ((OSC_MAX_W'(1) << w) - OSC_MAX_W'(1));
        return OSC_MAX_W'(phases >> (idx * w)) & mask;
    endfunction

    function automatic logic cfg_invalid(
        input logic [OSC_MAX_W-1:0]       period,
        input logic [OSC_PHASE_BUS_W-1:0] phases,
        input int                         num_ch,
        input int                         w
    );
        logic bad;
        bad = (period < OSC_MAX_W'(2));
        for (int i = 0; i < OSC_MAX_CH; i++) begin
            if (i < num_ch && phase_slice(phases, i, w) >= period) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/osc_channel.sv
// One oscillator channel: phase counter wrapping at the shared period and a registered output.
// Polarity input is tied low by the top unless OSC_POLARITY_EN is defined.
module osc_channel
    import osc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    input  logic             pol,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             osc
);

    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    assign wrap = (cnt_q == period - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            osc   <= 1'b0;
        end else begin
            osc <= en & ((cnt_q < high) ^ pol);
            if (load) begin
                cnt_q <= load_val;
            end else if (en) begin
                cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_phase_oscillator.sv
// NUM_CH square waves sharing period/high time with per-channel phase; config applied at period wrap.
// Define OSC_POLARITY_EN to add the per-channel cfg_pol output inversion.
module multi_phase_oscillator
    import osc_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int NUM_CH     = 4,
    parameter int DEF_PERIOD = 4,
    parameter int DEF_HIGH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [CNT_W-1:0]        cfg_high,
    input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
`ifdef OSC_POLARITY_EN
    input  logic [NUM_CH-1:0]       cfg_pol,
`endif
    output logic                    cfg_err,
    output logic [NUM_CH-1:0]       osc_out,
    output logic                    period_start
);

    osc_state_e state_q, state_d;

    logic [CNT_W-1:0]        per_q, high_q, m_q;
    logic [CNT_W-1:0]        sh_period, sh_high;
    logic [NUM_CH*CNT_W-1:0] sh_phase;
    logic [NUM_CH-1:0]       pol_q;

    logic transfer, reject, accept, apply, m_wrap;

    assign cfg_ready = (state_q == OSC_IDLE);
    assign transfer  = cfg_valid & cfg_ready;
    assign reject    = cfg_invalid(OSC_MAX_W'(cfg_period), OSC_PHASE_BUS_W'(cfg_phase),
                                   NUM_CH, CNT_W);
    assign accept    = transfer & ~reject;
    assign m_wrap    = (m_q == per_q - CNT_W'(1));
    // With en low the counters are frozen, so a pending config can land at once.
    assign apply     = (state_q == OSC_PENDING) & (~en | m_wrap);

    // NOTE: always_comb assigns every output a default first so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OSC_IDLE:    if (accept) state_d = OSC_PENDING;
            OSC_PENDING: if (apply)  state_d = OSC_IDLE;
            default:     state_d = OSC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OSC_IDLE;
            per_q        <= CNT_W'(DEF_PERIOD);
            high_q       <= CNT_W'(DEF_HIGH);
            m_q          <= '0;
            period_start <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_start <= en & m_wrap;
            cfg_err      <= transfer & reject;
            if (apply) begin
                per_q  <= sh_period;
                high_q <= sh_high;
                m_q    <= '0;
            end else if (en) begin
                m_q <= m_wrap ? '0 : m_q + CNT_W'(1);
            end
        end
    end

    // NOTE: shadow registers carry no reset; they are only read while PENDING,
    // which is reachable solely through a write, and reset clears PENDING.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_period <= cfg_period;
            sh_high   <= cfg_high;
            sh_phase  <= cfg_phase;
        end
    end

`ifdef OSC_POLARITY_EN
    logic [NUM_CH-1:0] sh_pol;

    always_ff @(posedge clk) begin
        if (accept) sh_pol <= cfg_pol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pol_q <= '0;
        else if (apply) pol_q <= sh_pol;
    end
`else
    assign pol_q = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] load_val;

        assign load_val = CNT_W'(phase_slice(OSC_PHASE_BUS_W'(sh_phase), i, CNT_W));

        osc_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .period   (per_q),
            .high     (high_q),
            .pol      (pol_q[i]),
            .load     (apply),
            .load_val (load_val),
            .osc      (osc_out[i])
        );
    end

endmodule
